// File: rtl/input_register.sv
`default_nettype none
// ============================================================================
// Module   : input_register
// Purpose  : Debounced switch-capture register with valid/overrun handshake
//            and a combinational bus driver.
// Revision : 1.0 - initial release
// ============================================================================
module input_register #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] switches,
  input  logic       load_btn,
  input  logic       data_out,
  input  logic       ack,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] held_value,
  output logic       valid,
  output logic       overrun
);

  localparam int c_CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_IDLE         = 2'd0;
  localparam logic [1:0] c_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] c_PRESSED      = 2'd2;
  localparam logic [1:0] c_RELEASE_WAIT = 2'd3;

  logic [7:0]         r_sw_s1;
  logic [7:0]         r_sw_s2;
  logic               r_btn_s1;
  logic               r_btn_s2;
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [7:0]         r_held;
  logic               r_valid;
  logic               r_overrun;

  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_capture;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_sw_s1  <= 8'h00;
      r_sw_s2  <= 8'h00;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_sw_s1  <= switches;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= load_btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // A press or release is accepted only after DEBOUNCE_CYCLES+1 agreeing samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (r_btn_s2) begin
          w_state_nxt = c_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      c_PRESS_WAIT: begin
        if (!r_btn_s2) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_LAST) begin
          w_state_nxt = c_PRESSED;
          w_cnt_nxt   = '0;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      c_PRESSED: begin
        if (!r_btn_s2) begin
          w_state_nxt = c_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      c_RELEASE_WAIT: begin
        if (r_btn_s2) begin
          w_state_nxt = c_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_LAST) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture takes priority over ack; a same-cycle ack suppresses the overrun.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_held    <= 8'h00;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_capture) begin
      r_held    <= r_sw_s2;
      r_valid   <= 1'b1;
      r_overrun <= r_valid & ~ack;
    end else if (ack && r_valid) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign held_value = r_held;
  assign valid      = r_valid;
  assign overrun    = r_overrun;
  assign bus_oe     = data_out;
  assign bus_out    = data_out ? r_held : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_input_register.sv
`default_nettype none
// Testbench for input_register: constant-table scenarios, directed corner
// sequences and a random run compared against an accept-after-N-samples model.
module tb_input_register;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] switches;
  logic       load_btn;
  logic       data_out;
  logic       ack;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] held_value;
  logic       valid;
  logic       overrun;

  always #5 clk = ~clk;

  input_register #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .clear      (clear),
    .switches   (switches),
    .load_btn   (load_btn),
    .data_out   (data_out),
    .ack        (ack),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .held_value (held_value),
    .valid      (valid),
    .overrun    (overrun)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: inputs reach the debouncer two edges late; the accepted
  // button level flips after D+1 consecutive samples of the opposite level.
  logic [7:0] m_held;
  logic       m_valid;
  logic       m_ovr;
  logic       m_lvl;
  int         m_run;
  logic       m_bd [2];
  logic [7:0] m_swd [2];

  task automatic model_reset();
    m_held = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_lvl = 1'b0; m_run = 0;
    m_bd[0] = 1'b0; m_bd[1] = 1'b0; m_swd[0] = 8'h00; m_swd[1] = 8'h00;
  endtask

  task automatic model_edge();
    logic       sb;
    logic [7:0] ssw;
    logic       cap;
    sb = m_bd[1];
    ssw = m_swd[1];
    m_bd[1] = m_bd[0];   m_bd[0] = load_btn;
    m_swd[1] = m_swd[0]; m_swd[0] = switches;
    cap = 1'b0;
    if (sb != m_lvl) m_run = m_run + 1;
    else m_run = 0;
    if (m_run == D + 1) begin
      m_lvl = sb;
      m_run = 0;
      cap = sb;
    end
    if (cap) begin
      m_ovr = m_valid & ~ack;
      m_held = ssw;
      m_valid = 1'b1;
    end else if (ack && m_valid) begin
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("model.held", held_value, m_held);
    check("model.valid", {7'b0, valid}, {7'b0, m_valid});
    check("model.overrun", {7'b0, overrun}, {7'b0, m_ovr});
    check("model.bus_out", bus_out, data_out ? m_held : 8'h00);
    check("model.bus_oe", {7'b0, bus_oe}, {7'b0, data_out});
  endtask

  task automatic cycle(input logic b, input logic [7:0] s, input logic a, input logic d);
    load_btn = b; switches = s; ack = a; data_out = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic check_regs(input string name, input logic [7:0] h, input logic v, input logic o);
    check({name, ".held"}, held_value, h);
    check({name, ".valid"}, {7'b0, valid}, {7'b0, v});
    check({name, ".overrun"}, {7'b0, overrun}, {7'b0, o});
  endtask

  typedef struct {
    logic [7:0] sw;
    int         press;
    logic       ack_after;
    logic [7:0] exp_held;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic b;
    tbl[0] = '{8'hA5, 12, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{8'h3C,  2, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'h11,  2, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[3] = '{8'h11, 10, 1'b0, 8'h11, 1'b1, 1'b0};
    tbl[4] = '{8'h22, 10, 1'b1, 8'h22, 1'b1, 1'b1};
    tbl[5] = '{8'h77,  4, 1'b0, 8'h22, 1'b0, 1'b0};
    tbl[6] = '{8'h78,  5, 1'b0, 8'h78, 1'b1, 1'b0};

    clear = 1'b1; switches = 8'hFF; load_btn = 1'b1; data_out = 1'b0; ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_regs("reset", 8'h00, 1'b0, 1'b0);
    check("reset.bus_out", bus_out, 8'h00);
    check("reset.bus_oe", {7'b0, bus_oe}, 8'h00);
    load_btn = 1'b0;
    clear = 1'b0;

    // Table: press length, release settle, then expected register contents.
    for (int i = 0; i < 7; i++) begin
      repeat (tbl[i].press) cycle(1'b1, tbl[i].sw, 1'b0, 1'b0);
      repeat (12) cycle(1'b0, tbl[i].sw, 1'b0, 1'b0);
      check_regs($sformatf("tbl%0d", i), tbl[i].exp_held, tbl[i].exp_valid, tbl[i].exp_ovr);
      if (tbl[i].ack_after) cycle(1'b0, tbl[i].sw, 1'b1, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Capture lands exactly on the 7th edge of a held press; only once.
    for (int e = 1; e <= 7; e++) begin
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      check($sformatf("lat.valid.e%0d", e), {7'b0, valid}, (e == 7) ? 8'h01 : 8'h00);
    end
    check_regs("lat", 8'hA5, 1'b1, 1'b0);
    repeat (6) cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 8'hA5, 1'b0, 1'b0);
    check_regs("single", 8'hA5, 1'b1, 1'b0);
    cycle(1'b0, 8'hA5, 1'b1, 1'b0);

    // Short bounce pulses never capture.
    cycle(1'b1, 8'h3C, 1'b0, 1'b0); cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h3C, 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0); cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 8'h3C, 1'b0, 1'b0);
    check_regs("bounce", 8'hA5, 1'b0, 1'b0);

    // Ack in the capture cycle: capture wins, no overrun.
    repeat (8) cycle(1'b1, 8'h44, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 8'h44, 1'b0, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      cycle(1'b1, 8'h33, (e == 7), 1'b0);
      if (e == 6) check_regs("ackcap.pre", 8'h44, 1'b1, 1'b0);
    end
    check_regs("ackcap", 8'h33, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 8'h33, 1'b0, 1'b0);

    // Overwrite without ack, then zero-latency bus drive.
    repeat (8) cycle(1'b1, 8'h5C, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 8'h5C, 1'b0, 1'b0);
    check_regs("ovr", 8'h5C, 1'b1, 1'b1);
    data_out = 1'b1;
    #1;
    check("bus.on.out", bus_out, 8'h5C);
    check("bus.on.oe", {7'b0, bus_oe}, 8'h01);
    data_out = 1'b0;
    #1;
    check("bus.off.out", bus_out, 8'h00);
    check("bus.off.oe", {7'b0, bus_oe}, 8'h00);
    cycle(1'b0, 8'h5C, 1'b1, 1'b0);
    check_regs("ovr.ack", 8'h5C, 1'b0, 1'b0);

    // Clear mid-press: immediate zeroing, held button restarts from idle.
    repeat (4) cycle(1'b1, 8'h9E, 1'b0, 1'b0);
    #2;
    clear = 1'b1;
    data_out = 1'b1;
    #1;
    check_regs("clr", 8'h00, 1'b0, 1'b0);
    check("clr.bus_out", bus_out, 8'h00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    data_out = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      cycle(1'b1, 8'h9E, 1'b0, 1'b0);
      check($sformatf("clr.valid.e%0d", e), {7'b0, valid}, (e == 7) ? 8'h01 : 8'h00);
    end
    check_regs("clr.cap", 8'h9E, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 8'h9E, 1'b0, 1'b0);

    // Random traffic against the model.
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) b = ~b;
      cycle(b, 8'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_register.md
INPUT_REGISTER -- requirements
Module: input_register

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized clk cycles needed to accept a press or release; legal range >= 2.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-high.
REQ-004 switches  input  8  raw user switch value, asynchronous to clk.
REQ-005 load_btn  input  1  raw user load button, active-high, asynchronous, bouncy.
REQ-006 data_out  input  1  control-word strobe: present the held value on the bus this cycle.
REQ-007 ack  input  1  control-word strobe: CPU has consumed the held value.
REQ-008 bus_out  output  8  value driven toward the bus; held value when data_out=1, else 8'h00.
REQ-009 bus_oe  output  1  bus drive enable; equals data_out.
REQ-010 held_value  output  8  currently held value, for LED display.
REQ-011 valid  output  1  held value is new and not yet acknowledged.
REQ-012 overrun  output  1  a new value was captured while valid was still 1.

Function
REQ-013 switches and load_btn SHALL each pass through a 2-flop synchronizer; all logic below uses the synchronized versions only.
REQ-014 Debounce FSM SHALL have states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a counter of width max(1, clog2(DEBOUNCE_CYCLES)).
REQ-015 IDLE: btn=1 -> PRESS_WAIT with counter=0; otherwise stay.
REQ-016 PRESS_WAIT: btn=0 -> IDLE with counter=0; btn=1 and counter==DEBOUNCE_CYCLES-1 -> PRESSED with capture; otherwise counter+1.
REQ-017 PRESSED: btn=0 -> RELEASE_WAIT with counter=0; otherwise stay; no further captures while held.
REQ-018 RELEASE_WAIT: btn=1 -> PRESSED with counter=0; btn=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter+1.
REQ-019 Capture SHALL load the synchronized switches sampled in the capture cycle into held_value and set valid=1 on the same edge.
REQ-020 Capture while valid=1 and ack=0 SHALL overwrite held_value and set overrun=1.
REQ-021 ack=1 without a capture SHALL clear valid and overrun on the next edge; ack while valid=0 has no effect.
REQ-022 Capture and ack in the same cycle: capture wins; next edge held_value=new, valid=1, overrun=0.
REQ-023 bus_out and bus_oe SHALL be combinational from data_out and held_value (zero latency); data_out does not alter valid.
REQ-024 Press-to-capture latency SHALL be 2 synchronizer cycles + 1 IDLE cycle + DEBOUNCE_CYCLES cycles from the first stable-high clk edge of load_btn.
REQ-025 One clean press and release SHALL yield exactly one capture; bounce shorter than DEBOUNCE_CYCLES yields no capture and no second capture.

Reset
REQ-026 While clear=1, immediately and independent of clk: state=IDLE, counter=0, synchronizer flops=0, held_value=8'h00, valid=0, overrun=0.
REQ-027 Assertion of clear mid-debounce SHALL abandon the press; a button still held at deassertion SHALL be treated as a new press from IDLE.
REQ-028 After clear deasserts, bus_out=8'h00 unless data_out=1, in which case bus_out=held_value=8'h00.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 switches=8'hA5, load_btn held high -> exactly one capture 7 edges after first sampled high; held_value=8'hA5, valid=1, overrun=0.
REQ-030 load_btn pulses high 2 cycles, low, high 2 cycles -> no capture; valid stays 0, held_value unchanged.
REQ-031 Capture 8'h11, release, capture 8'h22 with no ack -> held_value=8'h22, valid=1, overrun=1; then ack -> valid=0, overrun=0.
REQ-032 ack asserted in the capture cycle of 8'h33 while valid=1 -> held_value=8'h33, valid=1, overrun=0.
REQ-033 data_out=1 with held_value=8'h5C -> bus_out=8'h5C, bus_oe=1 in the same cycle; data_out=0 -> bus_out=8'h00, bus_oe=0.
REQ-034 clear pulsed during PRESS_WAIT with the button still held -> outputs zero immediately; capture occurs 7 edges after clear deasserts.
